// File: rtl/fifo_enq_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fifo_enq_arbiter
// Round-robin, burst-limited arbiter sharing one Fifo enqueue port among
// n_req producers; records the index of the last enqueued producer.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_enq_arbiter #(
  parameter int width = 8,
  parameter int n_req = 4,
  parameter int idx_w = 2,
  parameter int burst = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [n_req-1:0]       reqEn,
  input  logic [n_req*width-1:0] reqVal,
  output logic [n_req-1:0]       reqGnt,
  input  logic                   fifoEnqRdy,
  output logic                   fifoEnqEn,
  output logic [width-1:0]       fifoEnqVal,
  output logic [idx_w-1:0]       owner,
  output logic                   ownValid,
  output logic [idx_w-1:0]       lastTag
);

  localparam logic [0:0]       C_ST_IDLE  = 1'b0;
  localparam logic [0:0]       C_ST_OWN   = 1'b1;
  localparam logic [3:0]       C_CNT_LAST = 4'(burst - 1);
  localparam logic [idx_w-1:0] C_IDX_MAX  = idx_w'(n_req - 1);
  localparam logic [idx_w:0]   C_N_REQ    = (idx_w+1)'(n_req);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [idx_w-1:0] r_owner;
  logic [idx_w-1:0] r_prio;
  logic [idx_w-1:0] r_last_tag;
  logic [3:0]       r_cnt;

  logic [idx_w-1:0] w_winner;
  logic [idx_w-1:0] w_owner_inc;
  logic [idx_w:0]   w_scan;
  logic             w_in_own;
  logic             w_any_req;
  logic             w_own_req;
  logic             w_acc;
  logic             w_tenure_done;
  logic             w_release;
  logic [width-1:0] w_slice [n_req];

  for (genvar gi = 0; gi < n_req; gi++) begin : g_slice
    assign w_slice[gi] = reqVal[gi*width +: width];
  end

  // Scan from the highest offset down so the lowest offset from prio wins.
  always_comb begin
    w_winner = '0;
    w_scan   = '0;
    for (int k = n_req - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_prio} + (idx_w+1)'(k);
      if (w_scan >= C_N_REQ) begin
        w_scan = w_scan - C_N_REQ;
      end
      if (reqEn[w_scan[idx_w-1:0]]) begin
        w_winner = w_scan[idx_w-1:0];
      end
    end
  end

  assign w_in_own      = (r_state == C_ST_OWN);
  assign w_any_req     = |reqEn;
  assign w_own_req     = reqEn[r_owner];
  assign w_acc         = w_in_own & fifoEnqRdy & w_own_req;
  assign w_tenure_done = w_acc & (r_cnt == C_CNT_LAST);
  assign w_release     = w_in_own & (~w_own_req | w_tenure_done);
  assign w_owner_inc   = (r_owner == C_IDX_MAX) ? '0 : r_owner + idx_w'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE: if (w_any_req) w_state_nxt = C_ST_OWN;
      C_ST_OWN:  if (w_release) w_state_nxt = C_ST_IDLE;
      default:   w_state_nxt = C_ST_IDLE;
    endcase
  end

  // Stalls leave cnt untouched, so only accepted words consume the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= '0;
      r_cnt      <= '0;
      r_prio     <= '0;
      r_last_tag <= '0;
    end else begin
      if (!w_in_own && w_any_req) begin
        r_owner <= w_winner;
        r_cnt   <= '0;
      end else if (w_acc) begin
        r_cnt <= w_tenure_done ? 4'd0 : r_cnt + 4'd1;
      end
      if (w_release) begin
        r_prio <= w_owner_inc;
      end
      if (w_acc) begin
        r_last_tag <= r_owner;
      end
    end
  end

  always_comb begin
    fifoEnqEn  = 1'b0;
    reqGnt     = '0;
    fifoEnqVal = '0;
    owner      = '0;
    ownValid   = 1'b0;
    if (w_in_own) begin
      ownValid   = 1'b1;
      owner      = r_owner;
      fifoEnqVal = w_slice[r_owner];
      fifoEnqEn  = w_acc;
      if (w_acc) begin
        reqGnt = n_req'(1) << r_owner;
      end
    end
  end

  assign lastTag = r_last_tag;

endmodule
`default_nettype wire

// File: doc/fifo_enq_arbiter.md
Name: fifo_enq_arbiter

Overview:
- Round-robin arbiter that shares the enqueue side of one single-entry Fifo (enqRdy/enqEn/enqVal handshake) among n_req producers.
- A grant is held for up to `burst` consecutive enqueues, then ownership rotates.
- Registers the index of the producer whose word was last enqueued, so the consumer can route the data it dequeues.
- Sits between producer modules and the shared Fifo instance.

Parameters:
- width, 8, data word width in bits (matches Fifo width).
- n_req, 4, number of requesters; legal range 2..8.
- idx_w, 2, requester index width; must equal ceil(log2(n_req)).
- burst, 2, maximum enqueues per grant tenure; legal range 1..16.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- reqEn  input  n_req  bit i high: requester i has a word to enqueue.
- reqVal  input  n_req*width  packed data; requester i occupies bits [i*width +: width].
- reqGnt  output  n_req  one-hot; bit i high: requester i's word is accepted this cycle.
- fifoEnqRdy  input  1  from Fifo enqRdy.
- fifoEnqEn  output  1  to Fifo enqEn.
- fifoEnqVal  output  width  to Fifo enqVal.
- owner  output  idx_w  current owner index; 0 when ownValid=0.
- ownValid  output  1  high in state OWN.
- lastTag  output  idx_w  index of requester whose word was most recently enqueued.

Behaviour:
- Reset: asynchronous assertion of rst_n=0 forces the following immediately, independent of clk:
  - state=IDLE, owner=0, cnt=0, prio=0, lastTag=0.
  - Consequently reqGnt=0, fifoEnqEn=0, ownValid=0.
  - Mid-burst reset discards the tenure; no partial state survives.
- Internal registers:
  - state {IDLE, OWN}.
  - owner (idx_w).
  - cnt (4 bits).
  - prio (idx_w).
  - lastTag (idx_w).
- Winner (combinational): first i with reqEn[i]=1, scanning prio, prio+1, ... mod n_req.
- IDLE:
  - If any reqEn is high: owner<=winner, cnt<=0, state<=OWN.
  - Else remain in IDLE.
  - No enqueue ever occurs in IDLE (arbitration latency 1 cycle).
- OWN, per cycle:
  - acc = fifoEnqRdy & reqEn[owner].
  - Combinational outputs: fifoEnqEn=acc; reqGnt=acc ? (1<<owner) : 0; fifoEnqVal = reqVal slice[owner] (driven in OWN even when acc=0).
  - If reqEn[owner]=0: state<=IDLE, prio<=(owner+1) mod n_req. The drop takes priority; no enqueue that cycle.
  - Else if acc and cnt==burst-1: enqueue, state<=IDLE, prio<=(owner+1) mod n_req, cnt<=0.
  - Else if acc: enqueue, cnt<=cnt+1.
  - Else (stall, fifoEnqRdy=0): hold owner and cnt. Stalls do not consume burst.
- On every acc cycle: lastTag<=owner.
- Modulo wrap: prio wraps to 0 at n_req, including non-power-of-2 n_req (e.g. 3: 2 -> 0).
- Producer contract:
  - A producer keeps reqEn and reqVal stable until it sees reqGnt.
  - Dropping reqEn before grant is permitted and releases ownership.
- fifoEnqVal is a don't-care when fifoEnqEn=0.
- In IDLE, owner, fifoEnqVal and reqGnt are 0.
- Invariants (assert in bench):
  - reqGnt is one-hot or zero.
  - fifoEnqEn == |reqGnt.
  - fifoEnqEn implies fifoEnqRdy.

Test Plan:
- Reset values: rst_n=0 asserted between clock edges -> all outputs 0 immediately. Release, no requests -> stays IDLE, ownValid=0.
- Single requester: n_req=4, burst=2, reqEn=0001 held, fifoEnqRdy=1 from cycle 0 -> ownValid from cycle 1; enqueues at cycles 1,2,4,5,7,8; lastTag=0; reqGnt=0001 exactly on those cycles.
- Full contention: reqEn=1111 held, fifoEnqRdy=1 -> enqueue order 0,0,1,1,2,2,3,3,0,0. Data reqVal[i]=0xA0+i appears on fifoEnqVal in that order; lastTag follows 0,0,1,1,2,2,3,3.
- Backpressure: owner 2, fifoEnqRdy pattern 1,0,0,1 -> enqueues only at rdy=1 cycles; cnt is unaffected by stalls; ownership releases after the 2nd accepted word.
- Drop and wrap with n_req=3: owner 2 drops reqEn after 1 enqueue, reqEn=011 -> next cycle IDLE, prio=0; then owner=0.
- Reset mid-burst: owner 1, cnt=1, rst_n pulsed low -> immediate IDLE, reqGnt=0, lastTag=0. After release with reqEn=0010 -> owner=1, cnt restarts at 0, two enqueues.
